// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and default widths for the gshare predictor / branch resolve path.
package branch_resolve_unit_pkg;

    localparam int DEF_PC_W  = 32;
    localparam int DEF_IDX_W = 6;
    localparam int DEF_GHR_W = 6;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] pc;
        logic [DEF_GHR_W-1:0] ghr;
        logic                 pred;
    } pred_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_t;

    // History the fetch side resumes with once the branch's real direction is known.
    function automatic logic [DEF_GHR_W-1:0] ghrShift(input logic [DEF_GHR_W-1:0] ghr,
                                                     input logic                 taken);
        return {ghr[DEF_GHR_W-2:0], taken};
    endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order queue of in-flight branch predictions with push, pop and whole-queue clear.
module bru_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Clear drops everything by snapping the read pointer onto the write pointer.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        occ_d   = occ_q;
        if (clear_i) begin
            rdPtr_d = wrPtr_q;
            occ_d   = '0;
        end else begin
            if (push_i) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (pop_i)  rdPtr_d = rdPtr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
            if (push_i && !clear_i) mem_q[wrPtr_q] <= wdata_i;
        end
    end

    assign head_o      = mem_q[rdPtr_q];
    assign occupancy_o = occ_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Retires gshare predictions in order, feeds PHT/GHR updates back and redirects fetch on a mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int IDX_W = DEF_IDX_W,
    parameter int GHR_W = DEF_GHR_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_valid,
    input  logic [IDX_W-1:0]        push_pc,
    input  logic [GHR_W-1:0]        push_ghr,
    input  logic                    push_pred,
    output logic                    push_ready,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    input  logic [PC_W-1:0]         resolve_target,
    input  logic [PC_W-1:0]         resolve_fallthrough,
    output logic                    branch_update,
    output logic                    actual_outcome,
    output logic [IDX_W-1:0]        pc_branch_upd,
    output logic [GHR_W-1:0]        ghr_upd,
    output logic                    mispredict,
    output logic [PC_W-1:0]         redirect_pc,
    output logic [GHR_W-1:0]        ghr_restore,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    underflow_err,
    output logic [CNT_W-1:0]        stat_branches,
    output logic [CNT_W-1:0]        stat_mispredicts
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    bru_state_t  state_q, state_d;
    pred_entry_t pushEntry, headEntry;
    logic [OCC_W-1:0] occ;

    logic inRun, pushAcc, resolveAcc, mispAcc, underflowHit;

    logic             branchUpdate_q, branchUpdate_d;
    logic             actualOutcome_q, actualOutcome_d;
    logic [IDX_W-1:0] pcUpd_q, pcUpd_d;
    logic [GHR_W-1:0] ghrUpd_q, ghrUpd_d;
    logic             mispredict_q, mispredict_d;
    logic [PC_W-1:0]  redirectPc_q, redirectPc_d;
    logic [GHR_W-1:0] ghrRestore_q, ghrRestore_d;
    logic             underflowErr_q, underflowErr_d;
    logic [CNT_W-1:0] statBranches_q, statBranches_d;
    logic [CNT_W-1:0] statMisp_q, statMisp_d;

    assign inRun        = (state_q == RUN);
    assign push_ready   = inRun && (occ != OCC_W'(DEPTH));
    assign pushAcc      = push_valid && push_ready;
    assign resolveAcc   = resolve_valid && inRun && (occ != '0);
    assign underflowHit = resolve_valid && inRun && (occ == '0);
    assign mispAcc      = resolveAcc && (resolve_taken != headEntry.pred);

    assign pushEntry.pc   = push_pc;
    assign pushEntry.ghr  = push_ghr;
    assign pushEntry.pred = push_pred;

    // A mispredict empties the queue, so neither the pop nor a same-cycle push may land.
    bru_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pred_entry_t))
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pushAcc && !mispAcc),
        .pop_i       (resolveAcc && !mispAcc),
        .clear_i     (mispAcc),
        .wdata_i     (pushEntry),
        .head_o      (headEntry),
        .occupancy_o (occ)
    );

    always_comb begin
        state_d         = state_q;
        branchUpdate_d  = resolveAcc;
        actualOutcome_d = resolveAcc && resolve_taken;
        pcUpd_d         = resolveAcc ? headEntry.pc  : '0;
        ghrUpd_d        = resolveAcc ? headEntry.ghr : '0;
        mispredict_d    = mispAcc;
        redirectPc_d    = redirectPc_q;
        ghrRestore_d    = ghrRestore_q;
        underflowErr_d  = underflowErr_q || underflowHit;
        statBranches_d  = statBranches_q;
        statMisp_d      = statMisp_q;

        if (resolveAcc && (statBranches_q != {CNT_W{1'b1}}))
            statBranches_d = statBranches_q + CNT_W'(1);
        if (mispAcc && (statMisp_q != {CNT_W{1'b1}}))
            statMisp_d = statMisp_q + CNT_W'(1);

        // FLUSH covers the single wrong-path cycle after a redirect.
        case (state_q)
            RUN: begin
                if (mispAcc) begin
                    state_d      = FLUSH;
                    redirectPc_d = resolve_taken ? resolve_target : resolve_fallthrough;
                    ghrRestore_d = ghrShift(headEntry.ghr, resolve_taken);
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= RUN;
            branchUpdate_q  <= 1'b0;
            actualOutcome_q <= 1'b0;
            pcUpd_q         <= '0;
            ghrUpd_q        <= '0;
            mispredict_q    <= 1'b0;
            redirectPc_q    <= '0;
            ghrRestore_q    <= '0;
            underflowErr_q  <= 1'b0;
            statBranches_q  <= '0;
            statMisp_q      <= '0;
        end else begin
            state_q         <= state_d;
            branchUpdate_q  <= branchUpdate_d;
            actualOutcome_q <= actualOutcome_d;
            pcUpd_q         <= pcUpd_d;
            ghrUpd_q        <= ghrUpd_d;
            mispredict_q    <= mispredict_d;
            redirectPc_q    <= redirectPc_d;
            ghrRestore_q    <= ghrRestore_d;
            underflowErr_q  <= underflowErr_d;
            statBranches_q  <= statBranches_d;
            statMisp_q      <= statMisp_d;
        end
    end

    assign branch_update    = branchUpdate_q;
    assign actual_outcome   = actualOutcome_q;
    assign pc_branch_upd    = pcUpd_q;
    assign ghr_upd          = ghrUpd_q;
    assign mispredict       = mispredict_q;
    assign redirect_pc      = redirectPc_q;
    assign ghr_restore      = ghrRestore_q;
    assign occupancy        = occ;
    assign underflow_err    = underflowErr_q;
    assign stat_branches    = statBranches_q;
    assign stat_mispredicts = statMisp_q;

endmodule
